ring_counter: RTL and testbench

- Parameterised one-hot ring counter; a single active bit circulates through an N-bit register, advancing one position per clock.
- Used as a phase/slot sequencer (time-slot select, round-robin strobe, stepper phase) anywhere a decoded one-of-N rotating strobe is needed.
- Self-correcting: any non-one-hot register state is detected and forced back to the initial pattern.
- Also provides the binary slot index, a wrap strobe and an error flag.

---
 rtl/ring_counter.sv | 143 ++++++++++++++
 tb/tb_ring_counter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/ring_counter.sv
// ---------------------------------------------------------------------------
// ring_counter
//   One-hot ring counter used as a rotating one-of-N slot strobe. One '1'
//   moves through an N-bit register by one position on every clock. Any
//   state that is not one-hot is detected and replaced with the initial
//   pattern. The block also gives the binary slot index, a wrap strobe and
//   an error strobe.
//
// Parameters
//   N          ring width / number of slots (2..64)
//   INIT_POS   position of the '1' after reset or after self-correction
//   SHIFT_LEFT 1: rotate toward the MSB (out[N-1] wraps to out[0])
//              0: rotate toward the LSB (out[0] wraps to out[N-1])
//
// Ports
//   clk   in   rising-edge clock
//   rst   in   synchronous, active-high reset
//   out   out  [N-1:0]  one-hot ring state (registered)
//   idx   out  [IW-1:0] binary position of the set bit in out (registered)
//   wrap  out  one-cycle strobe; a rotation has just landed on INIT_POS
//   err   out  one-cycle strobe; an illegal state was found and corrected
// ---------------------------------------------------------------------------
module ring_counter #(
  parameter int N          = 4,
  parameter int INIT_POS   = 0,
  parameter int SHIFT_LEFT = 1,
  localparam int IW        = (N > 2) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic [N-1:0]  out,
  output logic [IW-1:0] idx,
  output logic          wrap,
  output logic          err
);

  // One-hot pattern with the single '1' at INIT_POS.
  function automatic logic [N-1:0] f_init_pattern();
    logic [N-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) begin
      if (i == INIT_POS) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // True when exactly one bit is set: non-zero, and clearing the lowest
  // set bit leaves nothing behind.
  function automatic logic f_is_onehot(input logic [N-1:0] v);
    logic [N-1:0] v_minus_one;
    v_minus_one = v - {{(N-1){1'b0}}, 1'b1};
    return (v != '0) && ((v & v_minus_one) == '0);
  endfunction

  // One-step rotation in the configured direction.
  function automatic logic [N-1:0] f_rotate(input logic [N-1:0] v);
    logic [N-1:0] r;
    if (SHIFT_LEFT != 0) begin
      r = {v[N-2:0], v[N-1]};
    end else begin
      r = {v[0], v[N-1:1]};
    end
    return r;
  endfunction

  // Binary encoder for a one-hot vector. The result is only meaningful
  // for a one-hot input, and the encoder is only applied to one.
  function automatic logic [IW-1:0] f_encode(input logic [N-1:0] v);
    logic [IW-1:0] e;
    e = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        e = e | IW'(i);
      end else begin
        e = e;
      end
    end
    return e;
  endfunction

  localparam logic [N-1:0]  INIT_VEC = f_init_pattern();
  localparam logic [IW-1:0] INIT_IDX = IW'(INIT_POS);

  logic [N-1:0]  r_out;
  logic [IW-1:0] r_idx;
  logic          r_wrap;
  logic          r_err;

  logic          w_legal;
  logic [N-1:0]  w_rot;
  logic [N-1:0]  w_next_out;
  logic [IW-1:0] w_next_idx;
  logic          w_next_wrap;
  logic          w_next_err;

  // Next-state selection: correct an illegal state, otherwise rotate.
  // The index is encoded from the next-state vector, so idx and out
  // always change on the same edge and never disagree.
  always_comb begin
    w_legal     = f_is_onehot(r_out);
    w_rot       = f_rotate(r_out);
    w_next_out  = INIT_VEC;
    w_next_idx  = INIT_IDX;
    w_next_wrap = 1'b0;
    w_next_err  = 1'b0;
    if (w_legal) begin
      w_next_out  = w_rot;
      w_next_idx  = f_encode(w_rot);
      w_next_wrap = w_rot[INIT_POS];
      w_next_err  = 1'b0;
    end else begin
      w_next_out  = INIT_VEC;
      w_next_idx  = INIT_IDX;
      w_next_wrap = 1'b0;
      w_next_err  = 1'b1;
    end
  end

  // State and output registers; reset has priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out  <= INIT_VEC;
      r_idx  <= INIT_IDX;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_out  <= w_next_out;
      r_idx  <= w_next_idx;
      r_wrap <= w_next_wrap;
      r_err  <= w_next_err;
    end
  end

  assign out  = r_out;
  assign idx  = r_idx;
  assign wrap = r_wrap;
  assign err  = r_err;

endmodule

// File: tb/tb_ring_counter.sv
// ---------------------------------------------------------------------------
// tb_ring_counter
//   Self-checking bench for ring_counter. Three instances share clk/rst:
//     a: N=4, INIT_POS=0, SHIFT_LEFT=1
//     b: N=4, INIT_POS=3, SHIFT_LEFT=0
//     c: N=8, INIT_POS=0, SHIFT_LEFT=1
//   A table of hand-computed per-edge expectations is applied first. A
//   free-running stretch follows, and then forced illegal states.
// ---------------------------------------------------------------------------
module tb_ring_counter;

  logic       clk;
  logic       rst;
  logic [3:0] a_out;
  logic [1:0] a_idx;
  logic       a_wrap;
  logic       a_err;
  logic [3:0] b_out;
  logic [1:0] b_idx;
  logic       b_wrap;
  logic       b_err;
  logic [7:0] c_out;
  logic [2:0] c_idx;
  logic       c_wrap;
  logic       c_err;

  int n_checks;
  int n_fail;

  ring_counter #(.N(4), .INIT_POS(0), .SHIFT_LEFT(1)) dut_a (
    .clk(clk), .rst(rst), .out(a_out), .idx(a_idx), .wrap(a_wrap), .err(a_err)
  );

  ring_counter #(.N(4), .INIT_POS(3), .SHIFT_LEFT(0)) dut_b (
    .clk(clk), .rst(rst), .out(b_out), .idx(b_idx), .wrap(b_wrap), .err(b_err)
  );

  ring_counter #(.N(8), .INIT_POS(0), .SHIFT_LEFT(1)) dut_c (
    .clk(clk), .rst(rst), .out(c_out), .idx(c_idx), .wrap(c_wrap), .err(c_err)
  );

  // 20 ns clock starting high: rising edges at 20, 40, 60 ...
  initial clk = 1'b1;
  always #10 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag,
                         input logic [3:0] ea_out, input logic [1:0] ea_idx, input logic ea_wrap, input logic ea_err,
                         input logic [3:0] eb_out, input logic [1:0] eb_idx, input logic eb_wrap, input logic eb_err,
                         input logic [7:0] ec_out, input logic [2:0] ec_idx, input logic ec_wrap, input logic ec_err);
    chk({tag, " a.out"},  64'(a_out),  64'(ea_out));
    chk({tag, " a.idx"},  64'(a_idx),  64'(ea_idx));
    chk({tag, " a.wrap"}, 64'(a_wrap), 64'(ea_wrap));
    chk({tag, " a.err"},  64'(a_err),  64'(ea_err));
    chk({tag, " b.out"},  64'(b_out),  64'(eb_out));
    chk({tag, " b.idx"},  64'(b_idx),  64'(eb_idx));
    chk({tag, " b.wrap"}, 64'(b_wrap), 64'(eb_wrap));
    chk({tag, " b.err"},  64'(b_err),  64'(eb_err));
    chk({tag, " c.out"},  64'(c_out),  64'(ec_out));
    chk({tag, " c.idx"},  64'(c_idx),  64'(ec_idx));
    chk({tag, " c.wrap"}, 64'(c_wrap), 64'(ec_wrap));
    chk({tag, " c.err"},  64'(c_err),  64'(ec_err));
  endtask

  typedef struct {
    logic       rst;
    logic [3:0] a_out;
    logic [1:0] a_idx;
    logic       a_wrap;
    logic [3:0] b_out;
    logic [1:0] b_idx;
    logic       b_wrap;
    logic [7:0] c_out;
    logic [2:0] c_idx;
    logic       c_wrap;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;

    // Each row: rst driven before the edge, then expected outputs after it.
    // Row 0 is the reset edge. Rows 1..10 count freely. Row 11 resets
    // while a=0100 and b=0010. Rows 13..14 hold reset for two edges.
    //              rst   a_out    ai    aw    b_out    bi    bw    c_out  ci    cw
    vecs[0]  = '{1'b1, 4'b0001, 2'd0, 1'b0, 4'b1000, 2'd3, 1'b0, 8'h01, 3'd0, 1'b0};
    vecs[1]  = '{1'b0, 4'b0010, 2'd1, 1'b0, 4'b0100, 2'd2, 1'b0, 8'h02, 3'd1, 1'b0};
    vecs[2]  = '{1'b0, 4'b0100, 2'd2, 1'b0, 4'b0010, 2'd1, 1'b0, 8'h04, 3'd2, 1'b0};
    vecs[3]  = '{1'b0, 4'b1000, 2'd3, 1'b0, 4'b0001, 2'd0, 1'b0, 8'h08, 3'd3, 1'b0};
    vecs[4]  = '{1'b0, 4'b0001, 2'd0, 1'b1, 4'b1000, 2'd3, 1'b1, 8'h10, 3'd4, 1'b0};
    vecs[5]  = '{1'b0, 4'b0010, 2'd1, 1'b0, 4'b0100, 2'd2, 1'b0, 8'h20, 3'd5, 1'b0};
    vecs[6]  = '{1'b0, 4'b0100, 2'd2, 1'b0, 4'b0010, 2'd1, 1'b0, 8'h40, 3'd6, 1'b0};
    vecs[7]  = '{1'b0, 4'b1000, 2'd3, 1'b0, 4'b0001, 2'd0, 1'b0, 8'h80, 3'd7, 1'b0};
    vecs[8]  = '{1'b0, 4'b0001, 2'd0, 1'b1, 4'b1000, 2'd3, 1'b1, 8'h01, 3'd0, 1'b1};
    vecs[9]  = '{1'b0, 4'b0010, 2'd1, 1'b0, 4'b0100, 2'd2, 1'b0, 8'h02, 3'd1, 1'b0};
    vecs[10] = '{1'b0, 4'b0100, 2'd2, 1'b0, 4'b0010, 2'd1, 1'b0, 8'h04, 3'd2, 1'b0};
    vecs[11] = '{1'b1, 4'b0001, 2'd0, 1'b0, 4'b1000, 2'd3, 1'b0, 8'h01, 3'd0, 1'b0};
    vecs[12] = '{1'b0, 4'b0010, 2'd1, 1'b0, 4'b0100, 2'd2, 1'b0, 8'h02, 3'd1, 1'b0};
    vecs[13] = '{1'b1, 4'b0001, 2'd0, 1'b0, 4'b1000, 2'd3, 1'b0, 8'h01, 3'd0, 1'b0};
    vecs[14] = '{1'b1, 4'b0001, 2'd0, 1'b0, 4'b1000, 2'd3, 1'b0, 8'h01, 3'd0, 1'b0};
    vecs[15] = '{1'b0, 4'b0010, 2'd1, 1'b0, 4'b0100, 2'd2, 1'b0, 8'h02, 3'd1, 1'b0};
    vecs[16] = '{1'b0, 4'b0100, 2'd2, 1'b0, 4'b0010, 2'd1, 1'b0, 8'h04, 3'd2, 1'b0};
    vecs[17] = '{1'b0, 4'b1000, 2'd3, 1'b0, 4'b0001, 2'd0, 1'b0, 8'h08, 3'd3, 1'b0};
    vecs[18] = '{1'b0, 4'b0001, 2'd0, 1'b1, 4'b1000, 2'd3, 1'b1, 8'h10, 3'd4, 1'b0};

    for (int v = 0; v < NV; v++) begin
      rst = vecs[v].rst;
      @(posedge clk);
      #1;
      chk_all($sformatf("vec%0d", v),
              vecs[v].a_out, vecs[v].a_idx, vecs[v].a_wrap, 1'b0,
              vecs[v].b_out, vecs[v].b_idx, vecs[v].b_wrap, 1'b0,
              vecs[v].c_out, vecs[v].c_idx, vecs[v].c_wrap, 1'b0);
    end

    // Free run. The table leaves a at position 0, b at position 3 and c at
    // position 4. After i further edges:
    //   a at i%4, b at 3-(i%4), c at (4+i)%8.
    for (int i = 1; i <= 16; i++) begin
      int         pa;
      int         pb;
      int         pc;
      logic [3:0] ea;
      logic [3:0] eb;
      logic [7:0] ec;
      @(posedge clk);
      #1;
      pa = i % 4;
      pb = 3 - (i % 4);
      pc = (4 + i) % 8;
      ea = 4'b0001 << pa;
      eb = 4'b0001 << pb;
      ec = 8'h01 << pc;
      chk_all($sformatf("run%0d", i),
              ea, 2'(pa), (pa == 0), 1'b0,
              eb, 2'(pb), (pb == 3), 1'b0,
              ec, 3'(pc), (pc == 0), 1'b0);
    end

    // Illegal all-zero state in a. The forced value stays in the register
    // after release until the next clock edge overwrites it.
    @(negedge clk);
    force dut_a.r_out = 4'b0000;
    #5;
    release dut_a.r_out;
    @(posedge clk);
    #1;
    chk("zero fix a.out",  64'(a_out),  64'(4'b0001));
    chk("zero fix a.idx",  64'(a_idx),  64'(2'd0));
    chk("zero fix a.err",  64'(a_err),  64'(1'b1));
    chk("zero fix a.wrap", 64'(a_wrap), 64'(1'b0));
    @(posedge clk);
    #1;
    chk("zero next a.out", 64'(a_out),  64'(4'b0010));
    chk("zero next a.idx", 64'(a_idx),  64'(2'd1));
    chk("zero next a.err", 64'(a_err),  64'(1'b0));

    // Illegal two-hot state 0110 in a.
    @(negedge clk);
    force dut_a.r_out = 4'b0110;
    #5;
    release dut_a.r_out;
    @(posedge clk);
    #1;
    chk("twohot fix a.out",  64'(a_out),  64'(4'b0001));
    chk("twohot fix a.idx",  64'(a_idx),  64'(2'd0));
    chk("twohot fix a.err",  64'(a_err),  64'(1'b1));
    chk("twohot fix a.wrap", 64'(a_wrap), 64'(1'b0));
    @(posedge clk);
    #1;
    chk("twohot next a.out", 64'(a_out), 64'(4'b0010));
    chk("twohot next a.err", 64'(a_err), 64'(1'b0));

    // Illegal state in b: it is corrected to b's own initial pattern, 1000.
    @(negedge clk);
    force dut_b.r_out = 4'b0101;
    #5;
    release dut_b.r_out;
    @(posedge clk);
    #1;
    chk("fix b.out",  64'(b_out),  64'(4'b1000));
    chk("fix b.idx",  64'(b_idx),  64'(2'd3));
    chk("fix b.err",  64'(b_err),  64'(1'b1));
    chk("fix b.wrap", 64'(b_wrap), 64'(1'b0));
    @(posedge clk);
    #1;
    chk("next b.out", 64'(b_out), 64'(4'b0100));
    chk("next b.idx", 64'(b_idx), 64'(2'd2));
    chk("next b.err", 64'(b_err), 64'(1'b0));

    // Illegal three-hot state in c: it is corrected to 01, then rotates to 02.
    @(negedge clk);
    force dut_c.r_out = 8'h83;
    #5;
    release dut_c.r_out;
    @(posedge clk);
    #1;
    chk("fix c.out",  64'(c_out), 64'(8'h01));
    chk("fix c.idx",  64'(c_idx), 64'(3'd0));
    chk("fix c.err",  64'(c_err), 64'(1'b1));
    @(posedge clk);
    #1;
    chk("next c.out", 64'(c_out), 64'(8'h02));
    chk("next c.err", 64'(c_err), 64'(1'b0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
